// File: rtl/ahb_mtx_out_stage_2to1.sv
// Output stage of a 2-to-1 AHB matrix: arbitrates two decoder requests onto slave port MI0,
// holding the grant across bursts and locked sequences and steering HWDATA to the data-phase owner.
module ahb_mtx_out_stage_2to1 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          sel_op0,
  input  logic [AW-1:0] addr_op0,
  input  logic [1:0]    trans_op0,
  input  logic          write_op0,
  input  logic [2:0]    size_op0,
  input  logic [2:0]    burst_op0,
  input  logic          lock_op0,
  input  logic [DW-1:0] wdata_op0,
  input  logic          sel_op1,
  input  logic [AW-1:0] addr_op1,
  input  logic [1:0]    trans_op1,
  input  logic          write_op1,
  input  logic [2:0]    size_op1,
  input  logic [2:0]    burst_op1,
  input  logic          lock_op1,
  input  logic [DW-1:0] wdata_op1,
  output logic          active_op0,
  output logic          active_op1,
  output logic          HSELM,
  output logic [AW-1:0] HADDRM,
  output logic [1:0]    HTRANSM,
  output logic          HWRITEM,
  output logic [2:0]    HSIZEM,
  output logic [2:0]    HBURSTM,
  output logic          HMASTLOCKM,
  output logic [DW-1:0] HWDATAM,
  input  logic          HREADYOUTM,
  output logic          HREADYMUXM
);

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_P0   = 2'd1,
    PORT_P1   = 2'd2
  } port_e;

  port_e addr_port_q, addr_port_d;
  port_e data_port_q, data_port_d;
  port_e arb_port, next_addr_port;
  logic  last_gnt_q, last_gnt_d;  // 0: P0 was granted last, 1: P1
  logic  req0, req1, hold0, hold1;

  // Handshake: HREADYOUTM=1 completes the current beat; only then does a new address phase
  // (grant, data owner, round-robin pointer) get registered. With HREADYOUTM=0 everything holds.
  assign HREADYMUXM = HREADYOUTM;

  always_comb begin
    req0  = sel_op0 & trans_op0[1];
    req1  = sel_op1 & trans_op1[1];
    // trans[0]=1 covers both SEQ and BUSY, i.e. a burst in progress
    hold0 = sel_op0 & (trans_op0[0] | lock_op0);
    hold1 = sel_op1 & (trans_op1[0] | lock_op1);
    arb_port = PORT_NONE;
    if (addr_port_q == PORT_P0 && hold0)      arb_port = PORT_P0;
    else if (addr_port_q == PORT_P1 && hold1) arb_port = PORT_P1;
    else if (req0 && req1)                    arb_port = last_gnt_q ? PORT_P0 : PORT_P1;
    else if (req0)                            arb_port = PORT_P0;
    else if (req1)                            arb_port = PORT_P1;
    next_addr_port = HREADYOUTM ? arb_port : addr_port_q;
  end

  always_comb begin
    active_op0 = (next_addr_port == PORT_P0);
    active_op1 = (next_addr_port == PORT_P1);
    HSELM      = 1'b0;
    HADDRM     = '0;
    HTRANSM    = 2'b00;
    HWRITEM    = 1'b0;
    HSIZEM     = 3'b000;
    HBURSTM    = 3'b000;
    HMASTLOCKM = 1'b0;
    case (next_addr_port)
      PORT_P0: begin
        HSELM      = 1'b1;
        HADDRM     = addr_op0;
        HTRANSM    = trans_op0;
        HWRITEM    = write_op0;
        HSIZEM     = size_op0;
        HBURSTM    = burst_op0;
        HMASTLOCKM = lock_op0;
      end
      PORT_P1: begin
        HSELM      = 1'b1;
        HADDRM     = addr_op1;
        HTRANSM    = trans_op1;
        HWRITEM    = write_op1;
        HSIZEM     = size_op1;
        HBURSTM    = burst_op1;
        HMASTLOCKM = lock_op1;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_port_d = next_addr_port;
    data_port_d = data_port_q;
    last_gnt_d  = last_gnt_q;
    if (HREADYOUTM) begin
      data_port_d = HTRANSM[1] ? next_addr_port : PORT_NONE;
      if (next_addr_port == PORT_P0) last_gnt_d = 1'b0;
      if (next_addr_port == PORT_P1) last_gnt_d = 1'b1;
    end
  end

  always_comb begin
    HWDATAM = '0;
    case (data_port_q)
      PORT_P0: HWDATAM = wdata_op0;
      PORT_P1: HWDATAM = wdata_op1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_port_q <= PORT_NONE;
      data_port_q <= PORT_NONE;
      last_gnt_q  <= 1'b1;
    end else begin
      addr_port_q <= addr_port_d;
      data_port_q <= data_port_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  a_one_hot_grant: assert property (@(posedge HCLK) disable iff (HRESET)
    !(active_op0 && active_op1));

endmodule

// File: tb/tb_ahb_mtx_out_stage_2to1.sv
// Bench for ahb_mtx_out_stage_2to1: directed scenarios followed by random traffic, all
// checked against a grant/ownership model kept as plain integers.
module tb_ahb_mtx_out_stage_2to1;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          HCLK;
  logic          rst;
  logic          hready;
  logic          sel_v[2];
  logic [AW-1:0] addr_v[2];
  logic [1:0]    trans_v[2];
  logic          write_v[2];
  logic [2:0]    size_v[2];
  logic [2:0]    burst_v[2];
  logic          lock_v[2];
  logic [DW-1:0] wdata_v[2];

  logic          active_op0, active_op1, HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic [2:0]    HSIZEM, HBURSTM;
  logic [DW-1:0] HWDATAM;

  int checks = 0;
  int errors = 0;

  // reference state: -1 = nobody, 0/1 = port
  int  owner = -1;
  int  downer = -1;
  int  last = 1;
  bit  valid = 0;
  int  nxt;

  ahb_mtx_out_stage_2to1 #(.AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESET(rst),
    .sel_op0(sel_v[0]), .addr_op0(addr_v[0]), .trans_op0(trans_v[0]), .write_op0(write_v[0]),
    .size_op0(size_v[0]), .burst_op0(burst_v[0]), .lock_op0(lock_v[0]), .wdata_op0(wdata_v[0]),
    .sel_op1(sel_v[1]), .addr_op1(addr_v[1]), .trans_op1(trans_v[1]), .write_op1(write_v[1]),
    .size_op1(size_v[1]), .burst_op1(burst_v[1]), .lock_op1(lock_v[1]), .wdata_op1(wdata_v[1]),
    .active_op0(active_op0), .active_op1(active_op1),
    .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
    .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM),
    .HREADYOUTM(hready), .HREADYMUXM(HREADYMUXM)
  );

  // clock
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Who should own the address phase given the current inputs and model state.
  function automatic int model_pick();
    bit r0, r1;
    if (!hready) return owner;
    if (owner >= 0 && sel_v[owner] &&
        (trans_v[owner] == 2'b11 || trans_v[owner] == 2'b01 || lock_v[owner]))
      return owner;
    r0 = sel_v[0] && trans_v[0] >= 2'b10;
    r1 = sel_v[1] && trans_v[1] >= 2'b10;
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic drive(int p, logic s, logic [1:0] t, logic l, logic [2:0] b);
    sel_v[p]   = s;
    trans_v[p] = t;
    lock_v[p]  = l;
    burst_v[p] = b;
    addr_v[p]  = $urandom;
    wdata_v[p] = $urandom;
    write_v[p] = 1'($urandom_range(0, 1));
    size_v[p]  = 3'($urandom_range(0, 2));
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  // want: -2 = no directed grant expectation, -1 = none, 0/1 = port
  task automatic cycle(int want);
    int obs_g;
    #1;
    nxt = model_pick();
    if (valid) begin
      chk("active_op0", 64'(active_op0), 64'(nxt == 0));
      chk("active_op1", 64'(active_op1), 64'(nxt == 1));
      chk("HSELM", 64'(HSELM), 64'(nxt >= 0));
      chk("HADDRM", 64'(HADDRM), (nxt >= 0) ? 64'(addr_v[nxt]) : 64'd0);
      chk("HTRANSM", 64'(HTRANSM), (nxt >= 0) ? 64'(trans_v[nxt]) : 64'd0);
      chk("HWRITEM", 64'(HWRITEM), (nxt >= 0) ? 64'(write_v[nxt]) : 64'd0);
      chk("HSIZEM", 64'(HSIZEM), (nxt >= 0) ? 64'(size_v[nxt]) : 64'd0);
      chk("HBURSTM", 64'(HBURSTM), (nxt >= 0) ? 64'(burst_v[nxt]) : 64'd0);
      chk("HMASTLOCKM", 64'(HMASTLOCKM), (nxt >= 0) ? 64'(lock_v[nxt]) : 64'd0);
      chk("HWDATAM", 64'(HWDATAM), (downer >= 0) ? 64'(wdata_v[downer]) : 64'd0);
      chk("HREADYMUXM", 64'(HREADYMUXM), 64'(hready));
      if (want != -2) begin
        obs_g = active_op0 ? 0 : (active_op1 ? 1 : -1);
        chk("directed_grant", 64'(obs_g), 64'(want));
      end
    end
    @(posedge HCLK);
    if (rst) begin
      owner = -1; downer = -1; last = 1; valid = 1;
    end else if (hready) begin
      downer = (nxt >= 0 && trans_v[nxt][1]) ? nxt : -1;
      if (nxt >= 0) last = nxt;
      owner = nxt;
    end
    @(negedge HCLK);
  endtask

  initial begin
    logic [DW-1:0] wd_hold;
    rst = 1'b1;
    hready = 1'b1;
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 2'b00, 1'b0, 3'b000);
    @(negedge HCLK);

    // reset with both requesting: P0 must win on the very first cycle afterwards
    drive(0, 1'b1, 2'b10, 1'b0, 3'b000);
    drive(1, 1'b1, 2'b10, 1'b0, 3'b000);
    cycle(-2);
    cycle(0);
    rst = 1'b0;
    drive(0, 1'b1, 2'b10, 1'b0, 3'b000);
    drive(1, 1'b1, 2'b10, 1'b0, 3'b000);
    #1;
    chk("t1_haddr_first", 64'(HADDRM), 64'(addr_v[0]));
    cycle(0);

    // round-robin on back-to-back single transfers
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 2'b10, 1'b0, 3'b000);
      drive(1, 1'b1, 2'b10, 1'b0, 3'b000);
      cycle((i % 2 == 0) ? 1 : 0);
    end

    // INCR4 burst from P0 holds off P1 until the last beat
    drive(0, 1'b0, 2'b00, 1'b0, 3'b000);
    drive(1, 1'b0, 2'b00, 1'b0, 3'b000);
    cycle(-1);
    drive(0, 1'b1, 2'b10, 1'b0, 3'b011);
    cycle(0);
    drive(0, 1'b1, 2'b11, 1'b0, 3'b011);
    drive(1, 1'b1, 2'b10, 1'b0, 3'b000);
    cycle(0);
    drive(0, 1'b1, 2'b11, 1'b0, 3'b011);
    cycle(0);
    drive(0, 1'b1, 2'b11, 1'b0, 3'b011);
    cycle(0);
    drive(0, 1'b0, 2'b00, 1'b0, 3'b000);
    drive(1, 1'b1, 2'b10, 1'b0, 3'b000);
    write_v[1] = 1'b1;
    cycle(1);

    // wait states during P1 write: grant and write data hold, P0 request waits
    drive(1, 1'b1, 2'b10, 1'b0, 3'b000);
    write_v[1] = 1'b1;
    hready = 1'b0;
    wd_hold = wdata_v[1];
    cycle(1);
    drive(0, 1'b1, 2'b10, 1'b0, 3'b000);
    cycle(1);
    #1;
    chk("t4_hwdata_hold", 64'(HWDATAM), 64'(wd_hold));
    cycle(1);
    hready = 1'b1;
    cycle(0);

    // locked P1 sequence with IDLE gap blocks P0 until the lock drops
    drive(0, 1'b0, 2'b00, 1'b0, 3'b000);
    drive(1, 1'b1, 2'b10, 1'b1, 3'b000);
    cycle(1);
    drive(1, 1'b1, 2'b00, 1'b1, 3'b000);
    drive(0, 1'b1, 2'b10, 1'b0, 3'b000);
    cycle(1);
    cycle(1);
    drive(1, 1'b1, 2'b00, 1'b0, 3'b000);
    cycle(0);

    // nobody selects the port
    drive(0, 1'b0, 2'b00, 1'b0, 3'b000);
    drive(1, 1'b0, 2'b00, 1'b0, 3'b000);
    cycle(-1);
    #1;
    chk("t6_hwdata_zero", 64'(HWDATAM), 64'd0);
    chk("t6_htrans_idle", 64'(HTRANSM), 64'd0);
    cycle(-1);

    // random traffic, wait states and occasional resets
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      hready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++)
        drive(p, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
      cycle(-2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
